// File: rtl/cram_arbiter.sv
// cram_arbiter: two-requester round-robin arbiter for the code RAM port.
// Ports: req/we/lock/address/wdata per requester in; ack/rvalid out;
// shared rdata out; ram_address/ram_in/ram_we/ram_oe to RAM; ram_out in.
module cram_arbiter #(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10,
  parameter int p_max_lock      = 8
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_req_0,
  input  logic                       i_w_req_1,
  input  logic                       i_w_we_0,
  input  logic                       i_w_we_1,
  input  logic                       i_w_lock_0,
  input  logic                       i_w_lock_1,
  input  logic [p_address_width-1:0] i_w_address_0,
  input  logic [p_address_width-1:0] i_w_address_1,
  input  logic [p_data_width-1:0]    i_w_wdata_0,
  input  logic [p_data_width-1:0]    i_w_wdata_1,
  output logic                       o_w_ack_0,
  output logic                       o_w_ack_1,
  output logic                       o_w_rvalid_0,
  output logic                       o_w_rvalid_1,
  output logic [p_data_width-1:0]    o_w_rdata,
  output logic [p_address_width-1:0] o_w_ram_address,
  output logic [p_data_width-1:0]    o_w_ram_in,
  output logic                       o_w_ram_we,
  output logic                       o_w_ram_oe,
  input  logic [p_data_width-1:0]    i_w_ram_out
);

  localparam int lc_w = $clog2(p_max_lock + 1);

  typedef enum logic [1:0] {
    st_idle,
    st_rd,
    st_wr
  } state_t;

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    lock_q, lock_d;
  logic                    owner_q, owner_d;
  logic [lc_w-1:0]         cnt_q, cnt_d;
  logic                    rd_id_q, rd_id_d;
  logic [p_data_width-1:0] rdata_q, rdata_d;

  logic [1:0]                 req;
  logic [1:0]                 we;
  logic [1:0]                 lk;
  logic                       win_v;
  logic                       win_id;
  logic                       win_we;
  logic                       win_lk;
  logic [p_address_width-1:0] win_addr;
  logic [p_data_width-1:0]    win_data;
  logic                       in_rd;
  logic                       issue;
  logic [lc_w-1:0]            cnt_n;

  assign req = {i_w_req_1, i_w_req_0};
  assign we  = {i_w_we_1, i_w_we_0};
  assign lk  = {i_w_lock_1, i_w_lock_0};

  always_comb begin
    win_v  = 1'b0;
    win_id = ptr_q;
    if (lock_q && req[owner_q]) begin
      win_v  = 1'b1;
      win_id = owner_q;
    end else if (req[ptr_q]) begin
      win_v  = 1'b1;
      win_id = ptr_q;
    end else if (req[~ptr_q]) begin
      win_v  = 1'b1;
      win_id = ~ptr_q;
    end
  end

  assign win_we   = we[win_id];
  assign win_lk   = lk[win_id];
  assign win_addr = win_id ? i_w_address_1 : i_w_address_0;
  assign win_data = win_id ? i_w_wdata_1 : i_w_wdata_0;
  assign in_rd    = (state_q == st_rd);

  // A write may not issue while last cycle's read data is on the bus.
  assign issue = win_v && !(in_rd && win_we) && !i_w_reset;

  assign o_w_ack_0    = issue && !win_id;
  assign o_w_ack_1    = issue && win_id;
  assign o_w_rvalid_0 = in_rd && !i_w_reset && !rd_id_q;
  assign o_w_rvalid_1 = in_rd && !i_w_reset && rd_id_q;

  always_comb begin
    o_w_rdata = rdata_q;
    if (i_w_reset) begin
      o_w_rdata = '0;
    end else if (in_rd) begin
      o_w_rdata = i_w_ram_out;
    end
  end

  assign o_w_ram_address = (win_v && !i_w_reset) ? win_addr : '0;
  assign o_w_ram_in      = (win_v && !i_w_reset) ? win_data : '0;
  assign o_w_ram_we      = issue && win_we;
  assign o_w_ram_oe      = !i_w_reset && ((issue && !win_we) || in_rd);

  assign cnt_n = ((lock_q && (owner_q == win_id)) ? cnt_q : '0)
               + lc_w'(1);

  always_comb begin
    state_d = st_idle;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rd_id_d = rd_id_q;
    rdata_d = in_rd ? i_w_ram_out : rdata_q;
    // Owner walked away: release and hand priority to the other side.
    if (lock_q && !req[owner_q]) begin
      lock_d = 1'b0;
      cnt_d  = '0;
      ptr_d  = ~owner_q;
    end
    if (issue) begin
      state_d = win_we ? st_wr : st_rd;
      if (!win_we) begin
        rd_id_d = win_id;
      end
      if (win_lk && (cnt_n != lc_w'(p_max_lock))) begin
        lock_d  = 1'b1;
        owner_d = win_id;
        cnt_d   = cnt_n;
      end else begin
        lock_d = 1'b0;
        cnt_d  = '0;
        ptr_d  = ~win_id;
      end
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q <= st_idle;
      ptr_q   <= 1'b0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      rd_id_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rd_id_q <= rd_id_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/cram_arbiter.md
Name: cram_arbiter

Overview:
- Two-requester arbiter sharing the single read/write port of the code RAM (cram).
- Requester 0 is the CPU instruction/data path; requester 1 is the debug/loader path.
- Round-robin grant, with an optional bounded lock for back-to-back accesses.
- Sequences the RAM's we/oe so that read data, which arrives one cycle after the address, is never gated off by a following write.

Parameters:
p_data_width, 16, RAM word width
p_address_width, 10, RAM address width
p_max_lock, 8, max consecutive grants one locked requester may hold (>=1)

Ports:
i_w_clk  in  1  clock (RAM clock domain)
i_w_reset  in  1  synchronous active-high reset
i_w_req_0 / i_w_req_1  in  1  access request, held until ack
i_w_we_0 / i_w_we_1  in  1  1=write, 0=read; stable while req
i_w_lock_0 / i_w_lock_1  in  1  request to retain grant for next access
i_w_address_0 / i_w_address_1  in  p_address_width  access address
i_w_wdata_0 / i_w_wdata_1  in  p_data_width  write data
o_w_ack_0 / o_w_ack_1  out  1  one-cycle pulse: request issued to RAM this cycle
o_w_rvalid_0 / o_w_rvalid_1  out  1  read data valid (cycle after read ack)
o_w_rdata  out  p_data_width  read data, shared; qualify with rvalid
o_w_ram_address  out  p_address_width  to cram address
o_w_ram_in  out  p_data_width  to cram write data
o_w_ram_we  out  1  to cram write enable
o_w_ram_oe  out  1  to cram output enable
i_w_ram_out  in  p_data_width  from cram gated output

Behaviour:
- Reset: all acks, rvalids, ram_we and ram_oe are 0; o_w_ram_address, o_w_ram_in and o_w_rdata are 0; priority pointer selects requester 0; lock counter is 0; state is IDLE. Reset asserted mid-access drops any pending rvalid; no ack is issued in the reset cycle.
- States:
  - IDLE: no access last cycle.
  - RD: a read issued last cycle; data is due this cycle.
  - WR: a write issued last cycle.
- Arbitration (each cycle, combinational winner):
  - If a lock is active and the lock owner's req=1, the owner wins.
  - Otherwise the requester at the priority pointer wins if requesting, else the other requester.
  - No winner if neither requests.
- Issue:
  - A winner is acked in the same cycle, i.e. the access is issued then.
  - ram_address and ram_in are driven combinationally from the winner's fields.
  - ram_we = winner we; ram_oe = !winner we.
- Read-data protection:
  - In state RD, ram_oe must be 1 and ram_we must be 0 for the whole cycle.
  - A winning write in RD is therefore not acked: one bubble cycle; the write is acked next cycle.
  - A winning read in RD is acked (back-to-back reads, throughput 1/cycle).
- Read response:
  - In RD, o_w_rdata = i_w_ram_out and rvalid of the requester acked last cycle = 1 for exactly one cycle.
  - Outside RD, rvalids are 0 and o_w_rdata holds its last value.
- Next state: RD after an acked read; WR after an acked write; IDLE otherwise, including stall cycles.
  - An idle cycle in RD with no new issue drives ram_oe=1, ram_we=0.
  - Idle outside RD drives ram_oe=0, ram_we=0.
- Priority pointer: after each ack, the pointer moves to the non-acked requester. It is not moved while a lock is held.
- Lock:
  - An ack with the requester's lock=1 starts or continues the lock and increments the counter.
  - The lock releases when the owner acks with lock=0, drops req, or reaches p_max_lock consecutive acks.
  - On release, the counter clears and the pointer moves to the other requester.
- Handshake rule: after ack, a requester may change its fields or drop req the next cycle. Req held after ack means a new access.
- Writes take effect on the ack cycle's clock edge. A read of the same address acked next cycle returns the new data.

Test Plan:
- Req_0 read at 0x005 (RAM holds 0x1234) -> ack_0 in cycle 0; cycle 1: rvalid_0=1, rdata=0x1234, ram_oe=1.
- Both requesters read continuously, no lock -> acks alternate 0,1,0,1; each rvalid follows its ack by 1 cycle; no bubbles.
- Req_0 read 0x010, then req_0 write 0x010=0xBEEF -> write ack delayed one cycle (stall, ram_we=0, ram_oe=1); then a read of 0x010 returns 0xBEEF.
- Req_1 holds lock=1 with p_max_lock=8 while req_0 is also pending -> 8 consecutive ack_1 pulses, then ack_0; pointer then favors req_1.
- Reset pulsed in the cycle after a read ack -> rvalid stays 0, all outputs 0; the first request after reset from both requesters grants 0.
- Simultaneous write by req_0 and read by req_1 from IDLE, pointer=0 -> ack_0 with ram_we=1, ram_oe=0; next cycle ack_1 (no stall after a write).
